// File: rtl/sddr_line_adapter.sv
// sddr_line_adapter: turns 32-bit CPU word accesses with byte strobes into
// 128-bit line read/write commands for sddr_ctrl. Partial writes are done as
// read-modify-write on a single resident line.
// Build option SDDR_LINE_BUFFER_EN: when defined the line stays resident as a
// write-back buffer and repeated accesses to it hit without DRAM traffic. When
// undefined every access misses; writes fill, merge and write straight back
// before responding.
module sddr_line_adapter #(
    parameter int ADDR_BITS = 27,
    parameter int LINE_BITS = 128
) (
    input  logic                 cpu_clock_i,
    input  logic                 reset_n_i,
    input  logic                 cpu_req_valid_i,
    output logic                 cpu_req_ready_o,
    input  logic [ADDR_BITS-1:0] cpu_addr_i,
    input  logic                 cpu_write_i,
    input  logic [31:0]          cpu_wdata_i,
    input  logic [3:0]           cpu_wstrb_i,
    output logic                 cpu_rsp_valid_o,
    output logic [31:0]          cpu_rdata_o,
    output logic                 data_cmd_valid_o,
    output logic [ADDR_BITS-1:0] data_cmd_address_o,
    output logic                 data_cmd_write_o,
    input  logic                 data_cmd_ack_i,
    output logic [LINE_BITS-1:0] data_cmd_data_o,
    input  logic                 data_rsp_ready_i,
    input  logic [LINE_BITS-1:0] data_data_i
);
    localparam int TAG_BITS = ADDR_BITS - 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_CMD,
        S_WB_WAIT,
        S_FILL_CMD,
        S_FILL_WAIT,
        S_RESPOND
    } state_t;

    state_t state, state_next;
    logic   started;

    // Resident line
    logic [LINE_BITS-1:0] line;
    logic [TAG_BITS-1:0]  tag;
    logic                 line_valid;
    logic                 dirty;

    // Latched CPU request, needed while a miss is being served
    logic [TAG_BITS-1:0]  req_tag;
    logic [1:0]           req_lane;
    logic                 req_write;
    logic [31:0]          req_wdata;
    logic [3:0]           req_wstrb;

    logic                 rsp_valid;
    logic [31:0]          rdata;

    logic                 accept;
    logic                 hit;
    logic                 rsp_in;
    logic                 enter_respond;
    logic [TAG_BITS-1:0]  cpu_tag;
    logic [1:0]           cpu_lane;
    logic [LINE_BITS-1:0] hit_line;
    logic [LINE_BITS-1:0] fill_line;
    logic                 unused_addr_bits;

    // Replace the strobed bytes of one 32-bit lane inside a line.
    function automatic logic [LINE_BITS-1:0] merge_word(
        input logic [LINE_BITS-1:0] base,
        input logic [1:0]           lane,
        input logic [31:0]          wdata,
        input logic [3:0]           wstrb
    );
        logic [LINE_BITS-1:0] merged;
        merged = base;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) merged[int'(lane)*32 + b*8 +: 8] = wdata[b*8 +: 8];
        end
        return merged;
    endfunction

    function automatic logic [31:0] lane_word(
        input logic [LINE_BITS-1:0] src,
        input logic [1:0]           lane
    );
        return src[int'(lane)*32 +: 32];
    endfunction

    assign cpu_tag          = cpu_addr_i[ADDR_BITS-1:4];
    assign cpu_lane         = cpu_addr_i[3:2];
    assign unused_addr_bits = ^cpu_addr_i[1:0];
    assign accept           = cpu_req_valid_i && cpu_req_ready_o;
    // line_valid is never left set in IDLE without the buffer, so this is
    // always a miss in that build.
    assign hit              = line_valid && (tag == cpu_tag);
    // Controller completions count only while one is actually outstanding.
    assign rsp_in           = data_rsp_ready_i && ((state == S_WB_WAIT) || (state == S_FILL_WAIT));
    assign hit_line         = merge_word(line, cpu_lane, cpu_wdata_i,
                                         cpu_write_i ? cpu_wstrb_i : 4'b0000);
    assign fill_line        = merge_word(data_data_i, req_lane, req_wdata,
                                         req_write ? req_wstrb : 4'b0000);
    assign enter_respond    = (state_next == S_RESPOND) && (state != S_RESPOND);

    // State register; 'started' holds ready low until the first edge after reset.
    always_ff @(posedge cpu_clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state   <= S_IDLE;
            started <= 1'b0;
        end else begin
            state   <= state_next;
            started <= 1'b1;
        end
    end

    // Next-state decision.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept && !hit) state_next = dirty ? S_WB_CMD : S_FILL_CMD;
            end
            S_WB_CMD: begin
                if (data_cmd_ack_i) state_next = S_WB_WAIT;
            end
            S_WB_WAIT: begin
`ifdef SDDR_LINE_BUFFER_EN
                if (rsp_in) state_next = S_FILL_CMD;
`else
                if (rsp_in) state_next = S_RESPOND;
`endif
            end
            S_FILL_CMD: begin
                if (data_cmd_ack_i) state_next = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
`ifdef SDDR_LINE_BUFFER_EN
                if (rsp_in) state_next = S_RESPOND;
`else
                if (rsp_in) state_next = req_write ? S_WB_CMD : S_RESPOND;
`endif
            end
            S_RESPOND: state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state; command fields only change on a state change,
    // so they are stable while a command waits for ack.
    always_comb begin
        cpu_req_ready_o    = started && (state == S_IDLE);
        data_cmd_valid_o   = 1'b0;
        data_cmd_write_o   = 1'b0;
        data_cmd_address_o = '0;
        data_cmd_data_o    = '0;
        case (state)
            S_WB_CMD: begin
                data_cmd_valid_o   = 1'b1;
                data_cmd_write_o   = 1'b1;
                data_cmd_address_o = {tag, 4'b0000};
                data_cmd_data_o    = line;
            end
            S_FILL_CMD: begin
                data_cmd_valid_o   = 1'b1;
                data_cmd_address_o = {req_tag, 4'b0000};
            end
            default: ;
        endcase
    end

    // Buffer control flags: valid/dirty bookkeeping.
    always_ff @(posedge cpu_clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            line_valid <= 1'b0;
            dirty      <= 1'b0;
        end else begin
            if (accept && hit && cpu_write_i) dirty <= 1'b1;
            if ((state == S_WB_WAIT) && rsp_in) dirty <= 1'b0;
            if ((state == S_FILL_WAIT) && rsp_in) begin
                line_valid <= 1'b1;
                dirty      <= req_write;
            end
`ifndef SDDR_LINE_BUFFER_EN
            if (enter_respond) line_valid <= 1'b0;
`endif
        end
    end

    // Request latch and line contents; pure data, guarded by the flags above.
    always_ff @(posedge cpu_clock_i) begin
        if (accept) begin
            req_tag   <= cpu_tag;
            req_lane  <= cpu_lane;
            req_write <= cpu_write_i;
            req_wdata <= cpu_wdata_i;
            req_wstrb <= cpu_wstrb_i;
        end
        if (accept && hit) line <= hit_line;
        if ((state == S_FILL_WAIT) && rsp_in) begin
            line <= fill_line;
            tag  <= req_tag;
        end
    end

    // CPU response: one-cycle pulse after a hit or on entry to RESPOND.
    always_ff @(posedge cpu_clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rsp_valid <= 1'b0;
            rdata     <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept && hit) begin
                rsp_valid <= 1'b1;
                rdata     <= lane_word(hit_line, cpu_lane);
            end else if (enter_respond) begin
                rsp_valid <= 1'b1;
                rdata     <= lane_word((state == S_FILL_WAIT) ? fill_line : line, req_lane);
            end
        end
    end

    assign cpu_rsp_valid_o = rsp_valid;
    assign cpu_rdata_o     = rdata;

endmodule

// File: tb/tb_sddr_line_adapter.sv
// Bench for sddr_line_adapter: random CPU traffic against a byte-level
// reference memory, a behavioural DRAM controller, and a buffer hit/miss model.
`timescale 1ns/1ps
module tb_sddr_line_adapter;
    localparam int ADDR_BITS = 27;
    localparam int LINE_BITS = 128;

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic                 wr;
    } cmd_t;

    logic                 cpu_clock_i = 1'b0;
    logic                 reset_n_i = 1'b1;
    logic                 cpu_req_valid_i = 1'b0;
    logic                 cpu_req_ready_o;
    logic [ADDR_BITS-1:0] cpu_addr_i = '0;
    logic                 cpu_write_i = 1'b0;
    logic [31:0]          cpu_wdata_i = '0;
    logic [3:0]           cpu_wstrb_i = '0;
    logic                 cpu_rsp_valid_o;
    logic [31:0]          cpu_rdata_o;
    logic                 data_cmd_valid_o;
    logic [ADDR_BITS-1:0] data_cmd_address_o;
    logic                 data_cmd_write_o;
    logic                 data_cmd_ack_i;
    logic [LINE_BITS-1:0] data_cmd_data_o;
    logic                 data_rsp_ready_i;
    logic [LINE_BITS-1:0] data_data_i;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference: what the CPU should observe, and what DRAM actually holds
    logic [127:0] ref_mem [int];
    logic [127:0] dram [int];
    cmd_t         cmd_log[$];

    // Buffer model (only consulted with the buffer enabled)
    bit bvalid = 0;
    bit bdirty = 0;
    int btag = 0;

    // Controller model state
    bit           ctl_busy = 0;
    int           ctl_lat = 0;
    int           ctl_idx = 0;
    logic [127:0] ctl_data = '0;
    int           ack_hold = 0;
    bit           hold_rsp = 0;
    bit           stray_req = 0;
    bit           stab_on = 0;
    bit           ack_new;
    logic [27:0]  stab_cmd;
    logic [127:0] stab_data;
    int           last_pulse_cyc = 0;

    sddr_line_adapter #(.ADDR_BITS(ADDR_BITS), .LINE_BITS(LINE_BITS)) dut (
        .cpu_clock_i        (cpu_clock_i),
        .reset_n_i          (reset_n_i),
        .cpu_req_valid_i    (cpu_req_valid_i),
        .cpu_req_ready_o    (cpu_req_ready_o),
        .cpu_addr_i         (cpu_addr_i),
        .cpu_write_i        (cpu_write_i),
        .cpu_wdata_i        (cpu_wdata_i),
        .cpu_wstrb_i        (cpu_wstrb_i),
        .cpu_rsp_valid_o    (cpu_rsp_valid_o),
        .cpu_rdata_o        (cpu_rdata_o),
        .data_cmd_valid_o   (data_cmd_valid_o),
        .data_cmd_address_o (data_cmd_address_o),
        .data_cmd_write_o   (data_cmd_write_o),
        .data_cmd_ack_i     (data_cmd_ack_i),
        .data_cmd_data_o    (data_cmd_data_o),
        .data_rsp_ready_i   (data_rsp_ready_i),
        .data_data_i        (data_data_i)
    );

    initial forever #5 cpu_clock_i = ~cpu_clock_i;
    initial forever begin
        @(posedge cpu_clock_i);
        cyc = cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] init_line(input int idx);
        logic [127:0] l;
        for (int k = 0; k < 4; k++)
            l[k*32 +: 32] = (32'(idx) * 32'h9E3779B1) ^ (32'(k + 1) * 32'h85EBCA6B);
        return l;
    endfunction

    function automatic logic [127:0] ref_line(input int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : init_line(idx);
    endfunction

    function automatic logic [127:0] dram_line(input int idx);
        return dram.exists(idx) ? dram[idx] : init_line(idx);
    endfunction

    task automatic check_outputs_zero(input string pfx);
        check_eq({pfx, "_cpu"}, {cpu_req_ready_o, cpu_rsp_valid_o, cpu_rdata_o}, '0);
        check_eq({pfx, "_cmd"}, {data_cmd_valid_o, data_cmd_write_o, data_cmd_address_o}, '0);
        check_eq({pfx, "_cmd_data"}, data_cmd_data_o, '0);
    endtask

    // Behavioural DRAM controller: ack when idle, answer two cycles after taking a command.
    initial begin
        data_cmd_ack_i   = 1'b1;
        data_rsp_ready_i = 1'b0;
        data_data_i      = '0;
        forever begin
            @(negedge cpu_clock_i);
            data_rsp_ready_i = 1'b0;
            if (stray_req) begin
                data_rsp_ready_i = 1'b1;
                data_data_i      = {4{32'hBAD0BAD0}};
                stray_req        = 0;
            end
            if (!reset_n_i) begin
                ctl_busy       = 0;
                stab_on        = 0;
                data_cmd_ack_i = 1'b1;
            end else begin
                if (ctl_busy) begin
                    if (ctl_lat > 0) ctl_lat--;
                    else if (!hold_rsp) begin
                        data_rsp_ready_i = 1'b1;
                        data_data_i      = ctl_data;
                        last_pulse_cyc   = cyc;
                        ctl_busy         = 0;
                    end
                end
                ack_new = !ctl_busy && (ack_hold == 0);
                if (data_cmd_valid_o && !ack_new) begin
                    if (stab_on) begin
                        check_eq("cmd_stable", {data_cmd_write_o, data_cmd_address_o}, stab_cmd);
                        check_eq("cmd_data_stable", data_cmd_data_o, stab_data);
                    end else begin
                        stab_cmd  = {data_cmd_write_o, data_cmd_address_o};
                        stab_data = data_cmd_data_o;
                        stab_on   = 1;
                    end
                    if (ack_hold > 0) ack_hold--;
                end
                data_cmd_ack_i = ack_new;
                if (data_cmd_valid_o && ack_new) begin
                    cmd_t c;
                    c.addr  = data_cmd_address_o;
                    c.wr    = data_cmd_write_o;
                    cmd_log.push_back(c);
                    ctl_idx = int'(data_cmd_address_o[ADDR_BITS-1:4]);
                    if (data_cmd_write_o) begin
                        check_eq("wb_data", data_cmd_data_o, ref_line(ctl_idx));
                        dram[ctl_idx] = data_cmd_data_o;
                    end else begin
                        ctl_data = dram_line(ctl_idx);
                    end
                    ctl_busy = 1;
                    ctl_lat  = 2;
                    stab_on  = 0;
                end
            end
        end
    end

    task automatic issue(input logic [ADDR_BITS-1:0] addr, input logic wr,
                         input logic [31:0] wd, input logic [3:0] ws, output int acc_cyc);
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge cpu_clock_i);
            if (cpu_req_ready_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_eq("ready_timeout", 0, 1);
        cpu_req_valid_i = 1'b1;
        cpu_addr_i      = addr;
        cpu_write_i     = wr;
        cpu_wdata_i     = wd;
        cpu_wstrb_i     = ws;
        acc_cyc         = cyc;
    endtask

    task automatic do_access(input logic [ADDR_BITS-1:0] addr, input logic wr,
                             input logic [31:0] wd, input logic [3:0] ws);
        int           idx;
        int           lane;
        int           start;
        int           acc_cyc;
        int           rsp_cyc;
        int           n_got;
        logic [127:0] l;
        logic [31:0]  exp_rd;
        bit           exp_hit;
        bit           seen;
        cmd_t         exp_q[$];
        cmd_t         c;
        idx  = int'(addr[ADDR_BITS-1:4]);
        lane = int'(addr[3:2]);
        l    = ref_line(idx);
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (ws[b]) l[lane*32 + b*8 +: 8] = wd[b*8 +: 8];
            ref_mem[idx] = l;
        end
        exp_rd = l[lane*32 +: 32];
`ifdef SDDR_LINE_BUFFER_EN
        exp_hit = bvalid && (btag == idx);
        if (!exp_hit) begin
            if (bdirty) begin
                c.addr = {23'(btag), 4'b0000}; c.wr = 1'b1; exp_q.push_back(c);
            end
            c.addr = {23'(idx), 4'b0000}; c.wr = 1'b0; exp_q.push_back(c);
            btag   = idx;
            bvalid = 1;
            bdirty = 0;
        end
        if (wr) bdirty = 1;
`else
        exp_hit = 0;
        c.addr = {23'(idx), 4'b0000}; c.wr = 1'b0; exp_q.push_back(c);
        if (wr) begin
            c.wr = 1'b1; exp_q.push_back(c);
        end
`endif
        start = cmd_log.size();
        issue(addr, wr, wd, ws, acc_cyc);
        seen    = 0;
        rsp_cyc = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge cpu_clock_i);
            cpu_req_valid_i = 1'b0;
            if (cpu_rsp_valid_o) begin
                seen    = 1;
                rsp_cyc = cyc;
                break;
            end
        end
        if (!seen) begin
            check_eq("rsp_timeout", 0, 1);
            return;
        end
        if (!wr) check_eq("rdata", cpu_rdata_o, exp_rd);
        check_eq("rsp_cycle", rsp_cyc, exp_hit ? acc_cyc + 1 : last_pulse_cyc + 1);
        check_eq("ready_at_rsp", cpu_req_ready_o, exp_hit);
        if (!exp_hit) begin
            @(negedge cpu_clock_i);
            check_eq("ready_return", cpu_req_ready_o, 1);
        end
        n_got = cmd_log.size() - start;
        check_eq("cmd_count", n_got, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n_got; i++) begin
            check_eq("cmd_addr", cmd_log[start + i].addr, exp_q[i].addr);
            check_eq("cmd_write", cmd_log[start + i].wr, exp_q[i].wr);
        end
    endtask

    initial begin
        logic [127:0]         pre;
        logic [127:0]         tl;
        logic [ADDR_BITS-1:0] a;
        int                   pool[4];
        int                   acc;
        int                   start;
        int                   k;
        bit                   ok;

        pool = '{4, 256, 516, 1024};
        pre  = {32'h0BADC0DE, 32'hCAFEF00D, 32'hDEADBEEF, 32'h01234567};
        dram[4]    = pre;
        ref_mem[4] = pre;

        // Reset state
        #1 reset_n_i = 1'b0;
        repeat (3) @(negedge cpu_clock_i);
        check_outputs_zero("reset");
        reset_n_i = 1'b1;
        #1 check_eq("ready_before_edge", cpu_req_ready_o, 0);
        @(negedge cpu_clock_i);
        check_eq("ready_after_edge", cpu_req_ready_o, 1);

        // Directed sequence
        do_access(27'h44, 1'b0, 32'h0, 4'h0);
        do_access(27'h48, 1'b0, 32'h0, 4'h0);
        do_access(27'h44, 1'b1, 32'h11223344, 4'b0101);
        do_access(27'h44, 1'b0, 32'h0, 4'h0);
        tl = ref_line(4);
        check_eq("merged_lane1", tl[63:32], 32'hDE22BE44);
`ifdef SDDR_LINE_BUFFER_EN
        // Two hits on consecutive cycles
        issue(27'h40, 1'b0, 32'h0, 4'h0, acc);
        @(negedge cpu_clock_i);
        check_eq("b2b_rsp0", cpu_rsp_valid_o, 1);
        check_eq("b2b_rdata0", cpu_rdata_o, tl[31:0]);
        check_eq("b2b_ready", cpu_req_ready_o, 1);
        cpu_addr_i = 27'h4C;
        @(negedge cpu_clock_i);
        cpu_req_valid_i = 1'b0;
        check_eq("b2b_rsp1", cpu_rsp_valid_o, 1);
        check_eq("b2b_rdata1", cpu_rdata_o, tl[127:96]);
`endif
        do_access(27'h1000, 1'b0, 32'h0, 4'h0);

        // Held ack with a stray completion pulse while the fill waits
        ack_hold = 10;
        fork
            do_access(27'h2040, 1'b0, 32'h0, 4'h0);
            begin
                repeat (4) @(negedge cpu_clock_i);
                stray_req = 1;
            end
        join
        check_eq("ack_hold_done", ack_hold, 0);

        // Random traffic over a few lines
        for (int i = 0; i < 40; i++) begin
            k = pool[$urandom_range(0, 3)];
            a = {23'(k), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            do_access(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
        end

        // Reset while a fill is outstanding
        do_access(27'h5000, 1'b0, 32'h0, 4'h0);
        hold_rsp = 1;
        start    = cmd_log.size();
        issue(27'h6000, 1'b0, 32'h0, 4'h0, acc);
        @(negedge cpu_clock_i);
        cpu_req_valid_i = 1'b0;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (cmd_log.size() > start) begin
                ok = 1;
                break;
            end
            @(negedge cpu_clock_i);
        end
        check_eq("rst_fill_taken", ok, 1);
        if (ok) check_eq("rst_fill_addr", cmd_log[start].addr, 27'h6000);
        repeat (2) @(negedge cpu_clock_i);
        #2 reset_n_i = 1'b0;
        #1 check_outputs_zero("midreset");
        hold_rsp = 0;
        bvalid   = 0;
        bdirty   = 0;
        ref_mem  = dram;
        repeat (2) @(negedge cpu_clock_i);
        reset_n_i = 1'b1;
        #1 check_eq("ready_post_rst", cpu_req_ready_o, 0);
        @(negedge cpu_clock_i);
        check_eq("ready_post_rst_edge", cpu_req_ready_o, 1);
        check_eq("no_cmd_after_rst", data_cmd_valid_o, 0);
        do_access(27'h40, 1'b0, 32'h0, 4'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
